// File: rtl/branch_resolve_unit_pkg.sv
// Shared types, update-entry layout and helpers for the branch resolve unit.
// The packed update entry is {pc, target, taken, cond}, 66 bits, cond at bit 0.
package branch_resolve_unit_pkg;

    localparam int unsigned BruDefaultQDepth = 4;

    localparam int unsigned BruEntryW    = 66;
    localparam int unsigned BruCondBit   = 0;
    localparam int unsigned BruTakenBit  = 1;
    localparam int unsigned BruTargetLsb = 2;
    localparam int unsigned BruPcLsb     = 34;

    typedef struct packed {
        logic        valid;
        logic        cond;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        taken;
        logic [31:0] target;
    } bru_slot_t;

    function automatic logic is_mispredict(input bru_slot_t s);
        return (s.pred_taken != s.taken) || (s.taken && (s.pred_target != s.target));
    endfunction

    function automatic logic [31:0] correct_pc(input bru_slot_t s);
        return s.taken ? s.target : s.pc + 32'd4;
    endfunction

    function automatic logic [BruEntryW-1:0] pack_entry(input bru_slot_t s);
        logic [BruEntryW-1:0] e;
        e = '0;
        e[BruPcLsb +: 32]     = s.pc;
        e[BruTargetLsb +: 32] = s.target;
        e[BruTakenBit]        = s.taken;
        e[BruCondBit]         = s.cond;
        return e;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, cnt} + 33'(inc);
        return sum[32] ? 32'hffff_ffff : sum[31:0];
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Execute-to-resolve slot inputs plus redirect and predictor-update outputs.
// master: execute/fetch side; slave: the resolve unit.
interface branch_resolve_unit_if;

    logic        s0_valid_i;
    logic        s0_cond_i;
    logic [31:0] s0_pc_i;
    logic        s0_pred_taken_i;
    logic [31:0] s0_pred_target_i;
    logic        s0_taken_i;
    logic [31:0] s0_target_i;

    logic        s1_valid_i;
    logic        s1_cond_i;
    logic [31:0] s1_pc_i;
    logic        s1_pred_taken_i;
    logic [31:0] s1_pred_target_i;
    logic        s1_taken_i;
    logic [31:0] s1_target_i;

    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        update_o;
    logic [31:0] update_pc_o;
    logic [31:0] update_target_o;
    logic        update_taken_o;
    logic        update_cond_o;

    modport master (
        output s0_valid_i, s0_cond_i, s0_pc_i, s0_pred_taken_i, s0_pred_target_i,
        output s0_taken_i, s0_target_i,
        output s1_valid_i, s1_cond_i, s1_pc_i, s1_pred_taken_i, s1_pred_target_i,
        output s1_taken_i, s1_target_i,
        input  redirect_o, redirect_pc_o,
        input  update_o, update_pc_o, update_target_o, update_taken_o, update_cond_o
    );

    modport slave (
        input  s0_valid_i, s0_cond_i, s0_pc_i, s0_pred_taken_i, s0_pred_target_i,
        input  s0_taken_i, s0_target_i,
        input  s1_valid_i, s1_cond_i, s1_pc_i, s1_pred_taken_i, s1_pred_target_i,
        input  s1_taken_i, s1_target_i,
        output redirect_o, redirect_pc_o,
        output update_o, update_pc_o, update_target_o, update_taken_o, update_cond_o
    );

endinterface

// File: rtl/branch_resolve_unit_update_fifo.sv
// Update queue: two ordered push ports, one pop port, registered storage.
// Depth must be a power of two; pointers wrap naturally.
module bru_update_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 66
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_a,
    input  logic [Width-1:0]        data_a,
    input  logic                    push_b,
    input  logic [Width-1:0]        data_b,
    input  logic                    pop,
    output logic [Width-1:0]        head,
    output logic [$clog2(Depth):0]  count,
    output logic [$clog2(Depth):0]  free,
    output logic                    full
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  wr_ptr_b;
    logic [CntW-1:0]  count_q;

    // Port b lands behind port a when both push.
    assign wr_ptr_b = wr_ptr_q + PtrW'(push_a);

    always_ff @(posedge clk) begin
        if (push_a) mem_q[wr_ptr_q] <= data_a;
        if (push_b) mem_q[wr_ptr_b] <= data_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PtrW'(push_a) + PtrW'(push_b);
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(push_a) + CntW'(push_b) - CntW'(pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign free  = CntW'(Depth) - count_q;
    assign full  = (count_q == CntW'(Depth));

endmodule

// File: rtl/branch_resolve_unit.sv
// Dual-slot branch resolution: registered redirect plus queued predictor updates.
// Define BRU_PERF_COUNTERS_EN to add saturating resolved/mispredict/dropped counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned QDEPTH = BruDefaultQDepth
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    branch_resolve_unit_if.slave bus
`ifdef BRU_PERF_COUNTERS_EN
    ,
    output logic [31:0]          perf_resolved_o,
    output logic [31:0]          perf_mispred_o,
    output logic [31:0]          perf_dropped_o
`endif
);

    localparam int unsigned CntW = $clog2(QDEPTH) + 1;

    bru_slot_t            slot0, slot1;
    logic                 mis0, mis1;
    logic                 act0, act1;
    logic                 acc0, acc1;
    logic [BruEntryW-1:0] ent0, ent1, first_ent, data_a, head;
    logic                 first_vld, second_vld;
    logic                 q_empty, q_full, pop, push_a, push_b;
    logic [CntW-1:0]      q_count, q_free;

    logic                 redirect_q, redirect_d;
    logic [31:0]          redirect_pc_q, redirect_pc_d;
    logic                 upd_vld_q, upd_vld_d;
    logic [BruEntryW-1:0] upd_ent_q, upd_ent_d;

    always_comb begin
        slot0 = '{valid: bus.s0_valid_i, cond: bus.s0_cond_i, pc: bus.s0_pc_i,
                  pred_taken: bus.s0_pred_taken_i, pred_target: bus.s0_pred_target_i,
                  taken: bus.s0_taken_i, target: bus.s0_target_i};
        slot1 = '{valid: bus.s1_valid_i, cond: bus.s1_cond_i, pc: bus.s1_pc_i,
                  pred_taken: bus.s1_pred_taken_i, pred_target: bus.s1_pred_target_i,
                  taken: bus.s1_taken_i, target: bus.s1_target_i};
    end

    always_comb begin
        mis0 = is_mispredict(slot0);
        mis1 = is_mispredict(slot1);
        ent0 = pack_entry(slot0);
        ent1 = pack_entry(slot1);

        // The cycle after a redirect is wrong-path; an older mispredict squashes slot 1.
        act0 = slot0.valid && !redirect_q;
        act1 = slot1.valid && !redirect_q && !(act0 && mis0);

        redirect_d    = (act0 && mis0) || (act1 && mis1);
        redirect_pc_d = '0;
        if (act0 && mis0) begin
            redirect_pc_d = correct_pc(slot0);
        end else if (act1 && mis1) begin
            redirect_pc_d = correct_pc(slot1);
        end

        // Space is judged on pre-pop occupancy; slot 1 is dropped before slot 0.
        acc0 = act0 && !q_full;
        acc1 = act1 && (q_free >= CntW'(acc0 ? 2 : 1));

        first_vld  = acc0 || acc1;
        second_vld = acc0 && acc1;
        first_ent  = acc0 ? ent0 : ent1;

        // An empty queue hands the oldest new entry straight to the output register.
        q_empty = (q_count == '0);
        pop     = !q_empty;
        push_a  = q_empty ? second_vld : first_vld;
        push_b  = q_empty ? 1'b0 : second_vld;
        data_a  = q_empty ? ent1 : first_ent;

        upd_vld_d = !q_empty || first_vld;
        upd_ent_d = upd_ent_q;
        if (!q_empty) begin
            upd_ent_d = head;
        end else if (first_vld) begin
            upd_ent_d = first_ent;
        end
    end

    bru_update_fifo #(
        .Depth (QDEPTH),
        .Width (BruEntryW)
    ) u_fifo (
        .clk    (clock_i),
        .rst    (reset_i),
        .push_a (push_a),
        .data_a (data_a),
        .push_b (push_b),
        .data_b (ent1),
        .pop    (pop),
        .head   (head),
        .count  (q_count),
        .free   (q_free),
        .full   (q_full)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            upd_vld_q     <= 1'b0;
            upd_ent_q     <= '0;
        end else begin
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            upd_vld_q     <= upd_vld_d;
            upd_ent_q     <= upd_ent_d;
        end
    end

    assign bus.redirect_o      = redirect_q;
    assign bus.redirect_pc_o   = redirect_pc_q;
    assign bus.update_o        = upd_vld_q;
    assign bus.update_pc_o     = upd_ent_q[BruPcLsb +: 32];
    assign bus.update_target_o = upd_ent_q[BruTargetLsb +: 32];
    assign bus.update_taken_o  = upd_ent_q[BruTakenBit];
    assign bus.update_cond_o   = upd_ent_q[BruCondBit];

`ifdef BRU_PERF_COUNTERS_EN
    logic [31:0] perf_resolved_q, perf_mispred_q, perf_dropped_q;
    logic [1:0]  n_resolved, n_dropped;

    always_comb begin
        n_resolved = {1'b0, act0} + {1'b0, act1};
        n_dropped  = {1'b0, act0 && !acc0} + {1'b0, act1 && !acc1};
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            perf_resolved_q <= '0;
            perf_mispred_q  <= '0;
            perf_dropped_q  <= '0;
        end else begin
            perf_resolved_q <= sat_add(perf_resolved_q, n_resolved);
            perf_mispred_q  <= sat_add(perf_mispred_q, {1'b0, redirect_d});
            perf_dropped_q  <= sat_add(perf_dropped_q, n_dropped);
        end
    end

    assign perf_resolved_o = perf_resolved_q;
    assign perf_mispred_o  = perf_mispred_q;
    assign perf_dropped_o  = perf_dropped_q;
`endif

endmodule
